// File: rtl/rob_commit_ctrl_if.sv
// Dispatch / writeback / commit / redirect bundle of the ROB commit controller.
// master = pipeline and PC buffer side, slave = rob_commit_ctrl.
`ifndef RobDepth
`define RobDepth 8
`endif
`ifndef AddrWidth
`define AddrWidth 32
`endif

interface rob_commit_ctrl_if #(
  parameter int DEPTH  = `RobDepth,
  parameter int COMMIT = 2,
  parameter int WB     = 2,
  parameter int DATA   = `AddrWidth
);
  localparam int ADDR = $clog2(DEPTH);
  localparam int CW   = $clog2(COMMIT) + 1;

  logic                     alloc_en;
  logic [ADDR-1:0]          alloc_id;
  logic                     full;
  logic [WB-1:0]            wb_en;
  logic [WB-1:0][ADDR-1:0]  wb_id;
  logic [WB-1:0]            wb_exc;
  logic [COMMIT-1:0]        commit_en;
  logic [CW-1:0]            commit_num;
  logic [ADDR-1:0]          redirect_id;
  logic [DATA-1:0]          redirect_pc;
  logic                     exc_valid;
  logic [DATA-1:0]          exc_pc;

  modport master (
    output alloc_en, wb_en, wb_id, wb_exc, redirect_pc,
    input  alloc_id, full, commit_en, commit_num, redirect_id, exc_valid, exc_pc
  );

  modport slave (
    input  alloc_en, wb_en, wb_id, wb_exc, redirect_pc,
    output alloc_id, full, commit_en, commit_num, redirect_id, exc_valid, exc_pc
  );
endinterface

// File: rtl/rob_commit_ctrl.sv
// In-order ROB commit controller: ID allocation, completion tracking, multi-retire and
// exception capture/flush. Optional ROB_COMMIT_STALL_CNT_EN adds a saturating stall_cnt output.
`ifndef RobDepth
`define RobDepth 8
`endif
`ifndef AddrWidth
`define AddrWidth 32
`endif

module rob_commit_ctrl #(
  parameter int DEPTH  = `RobDepth,
  parameter int COMMIT = 2,
  parameter int WB     = 2,
  parameter int DATA   = `AddrWidth
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  rob_commit_ctrl_if.slave    rob
`ifdef ROB_COMMIT_STALL_CNT_EN
  ,
  output logic [31:0]         stall_cnt
`endif
);
  localparam int ADDR  = $clog2(DEPTH);
  localparam int CW    = $clog2(COMMIT) + 1;
  localparam int CNT_W = ADDR + 1;

  typedef enum logic [1:0] {RUN, CAPTURE, FLUSH} state_t;

  state_t            state, state_next;
  logic [ADDR-1:0]   head, tail, head_n, tail_n;
  logic [CNT_W-1:0]  count, count_n;
  logic [DEPTH-1:0]  valid, done, exc;
  logic [DEPTH-1:0]  valid_n, done_n, exc_n;
  logic [DATA-1:0]   exc_pc_q;
  logic              exc_valid_q;
  logic [COMMIT-1:0] commit_en;
  logic [CW-1:0]     commit_num;
  logic [ADDR-1:0]   slot_id [COMMIT];
  logic              full, alloc_ok, tail_exc;

  assign full     = (count == CNT_W'(DEPTH)) || (state != RUN);
  assign alloc_ok = rob.alloc_en && !full;
  assign tail_exc = (state == RUN) && (count != '0) && valid[tail] && done[tail] && exc[tail];

  // Retire slots form a prefix: a slot commits only if every older slot does too.
  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    logic chain;
    commit_en  = '0;
    commit_num = '0;
    chain      = (state == RUN);
    for (int k = 0; k < COMMIT; k++) begin
      slot_id[k]   = ADDR'((int'(tail) + k) % DEPTH);
      chain        = chain && (k < int'(count)) && valid[slot_id[k]]
                     && done[slot_id[k]] && !exc[slot_id[k]];
      commit_en[k] = chain;
      if (chain) commit_num = commit_num + CW'(1);
    end
  end

  always_comb begin
    valid_n = valid;
    done_n  = done;
    exc_n   = exc;
    for (int i = 0; i < WB; i++) begin
      if (state == RUN && rob.wb_en[i] && int'(rob.wb_id[i]) < DEPTH && valid[rob.wb_id[i]]) begin
        done_n[rob.wb_id[i]] = 1'b1;
        if (rob.wb_exc[i]) exc_n[rob.wb_id[i]] = 1'b1;
      end
    end
    for (int k = 0; k < COMMIT; k++) begin
      if (commit_en[k]) valid_n[slot_id[k]] = 1'b0;
    end
    // The head slot is never the target of a same-cycle commit, so set/clear order is safe.
    if (alloc_ok) begin
      valid_n[head] = 1'b1;
      done_n[head]  = 1'b0;
      exc_n[head]   = 1'b0;
    end
    head_n  = alloc_ok ? ((head == ADDR'(DEPTH - 1)) ? '0 : head + ADDR'(1)) : head;
    tail_n  = ADDR'((int'(tail) + int'(commit_num)) % DEPTH);
    count_n = CNT_W'(int'(count) + int'(alloc_ok) - int'(commit_num));
  end

  always_comb begin
    state_next = state;
    unique case (state)
      RUN:     if (tail_exc) state_next = CAPTURE;
      CAPTURE: state_next = FLUSH;
      FLUSH:   state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // NOTE: valid/done/exc are control flags and must be reset; PCs live in the PC buffer,
  // so there is no payload array here that would need (or want) a reset.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset || flush || state == FLUSH) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
      done  <= '0;
      exc   <= '0;
    end else begin
      head  <= head_n;
      tail  <= tail_n;
      count <= count_n;
      valid <= valid_n;
      done  <= done_n;
      exc   <= exc_n;
    end
  end

  // exc_pc survives an external flush so software can still inspect the last fault.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      exc_valid_q <= 1'b0;
      exc_pc_q    <= '0;
    end else if (flush) begin
      state       <= RUN;
      exc_valid_q <= 1'b0;
    end else begin
      state       <= state_next;
      exc_valid_q <= (state == CAPTURE);
      if (state == CAPTURE) exc_pc_q <= rob.redirect_pc;
    end
  end

`ifdef ROB_COMMIT_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (state == RUN && count != '0 && commit_num == '0 && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

  assign rob.alloc_id    = head;
  assign rob.full        = full;
  assign rob.commit_en   = commit_en;
  assign rob.commit_num  = commit_num;
  assign rob.redirect_id = tail;
  assign rob.exc_valid   = exc_valid_q;
  assign rob.exc_pc      = exc_pc_q;
endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Self-checking bench for rob_commit_ctrl: directed steps plus a random phase, all
// compared against an in-order queue model of the reorder buffer.
module tb_rob_commit_ctrl;
  localparam int DEPTH  = 8;
  localparam int COMMIT = 2;
  localparam int WB     = 2;
  localparam int DATA   = 32;

  logic clk = 1'b0;
  logic reset, flush;
  always #5 clk = ~clk;

  rob_commit_ctrl_if #(.DEPTH(DEPTH), .COMMIT(COMMIT), .WB(WB), .DATA(DATA)) bus ();

  // PC buffer stand-in: written when the model accepts an allocation.
  logic [DATA-1:0] pcmem [DEPTH];
  assign bus.redirect_pc = pcmem[bus.redirect_id];

`ifdef ROB_COMMIT_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  rob_commit_ctrl #(.DEPTH(DEPTH), .COMMIT(COMMIT), .WB(WB), .DATA(DATA)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .rob   (bus)
`ifdef ROB_COMMIT_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  // Reference model: program-ordered queue of in-flight entries.
  typedef struct {
    int id;
    bit done;
    bit exc;
  } ent_t;

  ent_t            q[$];
  int              m_head  = 0;
  int              phase   = 0;   // 0 run, 1 capture, 2 flush
  logic [DATA-1:0] m_exc_pc = '0;
  int              errors  = 0;
  int              checks  = 0;

  function automatic int m_commits();
    int n = 0;
    if (phase != 0) return 0;
    while (n < COMMIT && n < q.size() && q[n].done && !q[n].exc) n++;
    return n;
  endfunction

  function automatic int m_tail();
    return (q.size() > 0) ? q[0].id : m_head;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, compare current outputs with the model, advance the model.
  task automatic tick(input bit rst, input bit fl, input bit al,
                      input logic [1:0] we, input int id0, input int id1,
                      input logic [1:0] wx, input logic [DATA-1:0] pc);
    int  n;
    int  wid[2];
    bit  trig, mfull;
    logic [COMMIT-1:0] ce;
    reset          = rst;
    flush          = fl;
    bus.alloc_en   = al;
    bus.wb_en      = we;
    bus.wb_id[0]   = 3'(id0);
    bus.wb_id[1]   = 3'(id1);
    bus.wb_exc     = wx;
    wid[0] = id0;
    wid[1] = id1;

    n     = m_commits();
    ce    = COMMIT'((1 << n) - 1);
    mfull = (q.size() == DEPTH) || (phase != 0);
    check("alloc_id",    bus.alloc_id,    m_head);
    check("full",        bus.full,        mfull);
    check("commit_en",   bus.commit_en,   ce);
    check("commit_num",  bus.commit_num,  n);
    check("redirect_id", bus.redirect_id, m_tail());
    check("exc_valid",   bus.exc_valid,   phase == 2);
    check("exc_pc",      bus.exc_pc,      m_exc_pc);

    if (rst) begin
      q.delete();
      m_head   = 0;
      phase    = 0;
      m_exc_pc = '0;
    end else if (fl) begin
      q.delete();
      m_head = 0;
      phase  = 0;
    end else if (phase == 0) begin
      trig = (q.size() > 0) && q[0].done && q[0].exc;
      for (int i = 0; i < WB; i++) begin
        if (we[i]) begin
          for (int j = 0; j < q.size(); j++) begin
            if (q[j].id == wid[i]) begin
              q[j].done = 1'b1;
              if (wx[i]) q[j].exc = 1'b1;
            end
          end
        end
      end
      repeat (n) void'(q.pop_front());
      if (al && !mfull) begin
        pcmem[m_head] = pc;
        q.push_back('{id: m_head, done: 1'b0, exc: 1'b0});
        m_head = (m_head + 1) % DEPTH;
      end
      if (trig) phase = 1;
    end else if (phase == 1) begin
      m_exc_pc = pcmem[q[0].id];
      phase    = 2;
    end else begin
      q.delete();
      m_head = 0;
      phase  = 0;
    end

    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tick(0, 0, 0, 2'b00, 0, 0, 2'b00, '0);
  endtask

  task automatic alloc(input logic [DATA-1:0] pc);
    tick(0, 0, 1, 2'b00, 0, 0, 2'b00, pc);
  endtask

  task automatic do_reset();
    tick(1, 0, 0, 2'b00, 0, 0, 2'b00, '0);
  endtask

  initial begin
    int sz, id0, id1, rr;
    logic [1:0] wx;
    for (int i = 0; i < DEPTH; i++) pcmem[i] = '0;
    reset        = 1'b1;
    flush        = 1'b0;
    bus.alloc_en = 1'b0;
    bus.wb_en    = '0;
    bus.wb_id    = '0;
    bus.wb_exc   = '0;
    @(posedge clk);
    #1;

    // Reset state.
    do_reset();
    check("rst_commit_en",   bus.commit_en,   0);
    check("rst_full",        bus.full,        0);
    check("rst_alloc_id",    bus.alloc_id,    0);
    check("rst_redirect_id", bus.redirect_id, 0);
    check("rst_exc_valid",   bus.exc_valid,   0);
    check("rst_exc_pc",      bus.exc_pc,      0);

    // Fill all eight entries, then try a ninth.
    for (int i = 0; i < DEPTH; i++) alloc(32'h100 + 32'(i * 4));
    check("fill_full",     bus.full,     1);
    check("fill_alloc_id", bus.alloc_id, 0);
    alloc(32'hdead);
    check("ninth_ignored", bus.alloc_id, 0);
    check("ninth_count",   dut.count,    8);

    // Out-of-order completion: ID 1 alone must not retire, then ID 0 releases both.
    do_reset();
    for (int i = 0; i < 4; i++) alloc(32'h200 + 32'(i * 4));
    tick(0, 0, 0, 2'b01, 1, 0, 2'b00, '0);
    check("wb1_only_commit", bus.commit_en, 2'b00);
    tick(0, 0, 0, 2'b01, 0, 0, 2'b00, '0);
    check("wb0_commit_en",  bus.commit_en,  2'b11);
    check("wb0_commit_num", bus.commit_num, 2);
    idle();
    check("wb0_tail", bus.redirect_id, 2);

    // Both IDs in one cycle on separate ports.
    do_reset();
    for (int i = 0; i < 4; i++) alloc(32'h300 + 32'(i * 4));
    tick(0, 0, 0, 2'b11, 1, 0, 2'b00, '0);
    check("dual_commit_en", bus.commit_en, 2'b11);
    idle();
    check("dual_tail", bus.redirect_id, 2);

    // Full ROB: commit two (allocation blocked), then allocate with head wrapping.
    do_reset();
    for (int i = 0; i < DEPTH; i++) alloc(32'h400 + 32'(i * 4));
    tick(0, 0, 0, 2'b11, 0, 1, 2'b00, '0);
    alloc(32'h999);
    alloc(32'h480);
    check("wrap_count", dut.count,       7);
    check("wrap_head",  bus.alloc_id,    1);
    check("wrap_tail",  bus.redirect_id, 2);
    check("wrap_full",  bus.full,        0);
    tick(0, 0, 0, 2'b01, 2, 0, 2'b00, '0);
    alloc(32'h484);
    check("same_cycle_count", dut.count,       7);
    check("same_cycle_tail",  bus.redirect_id, 3);

    // Exception at the tail; both ports hit ID 0, only port 1 reports the exception.
    do_reset();
    alloc(32'h1000);
    for (int i = 1; i < 4; i++) alloc(32'h1000 + 32'(i * 4));
    tick(0, 0, 0, 2'b11, 0, 0, 2'b10, '0);
    check("exc_no_commit", bus.commit_en, 2'b00);
    idle();
    check("capture_full", bus.full, 1);
    alloc(32'hbad0);
    check("flush_exc_valid", bus.exc_valid, 1);
    check("flush_exc_pc",    bus.exc_pc,    32'h1000);
    alloc(32'hbad4);
    check("post_exc_valid", bus.exc_valid, 0);
    check("post_count",     dut.count,     0);
    check("post_alloc_id",  bus.alloc_id,  0);

    // External flush while in CAPTURE: no pulse, exc_pc retained.
    alloc(32'h2000);
    alloc(32'h2004);
    tick(0, 0, 0, 2'b01, 0, 0, 2'b01, '0);
    idle();
    tick(0, 1, 0, 2'b00, 0, 0, 2'b00, '0);
    check("xflush_exc_valid", bus.exc_valid, 0);
    check("xflush_exc_pc",    bus.exc_pc,    32'h1000);
    check("xflush_full",      bus.full,      0);
    idle();
    check("xflush_no_pulse", bus.exc_valid, 0);

    // Reset in the middle of a commit.
    for (int i = 0; i < 3; i++) alloc(32'h3000 + 32'(i * 4));
    tick(0, 0, 0, 2'b11, 0, 1, 2'b00, '0);
    check("midrst_commit_en", bus.commit_en, 2'b11);
    do_reset();
    check("midrst_commit_en0", bus.commit_en,   0);
    check("midrst_alloc_id",   bus.alloc_id,    0);
    check("midrst_redirect",   bus.redirect_id, 0);
    check("midrst_exc_pc",     bus.exc_pc,      0);

    // Random traffic against the queue model.
    for (int c = 0; c < 600; c++) begin
      rr  = int'($urandom_range(0, 299));
      sz  = q.size();
      id0 = (sz > 0 && $urandom_range(0, 3) != 0) ? q[$urandom_range(0, sz - 1)].id
                                                   : int'($urandom_range(0, DEPTH - 1));
      id1 = (sz > 0 && $urandom_range(0, 3) != 0) ? q[$urandom_range(0, sz - 1)].id
                                                   : int'($urandom_range(0, DEPTH - 1));
      wx  = {($urandom_range(0, 39) == 0), ($urandom_range(0, 39) == 0)};
      tick(rr == 0, rr == 1, $urandom_range(0, 9) < 6, 2'($urandom), id0, id1, wx,
           DATA'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rob_commit_ctrl.md
Name: rob_commit_ctrl

Overview:
- In-order commit controller for the reorder buffer.
- Allocates ROB IDs at dispatch, in lockstep with PC buffer writes.
- Tracks writeback completion and exception status per entry.
- Retires up to COMMIT oldest completed entries per cycle; this drives the PC buffer read enables.
- On an exception at the oldest entry, reads the faulting PC through the PC buffer's issue_id/issue_pc port, latches it, and pulses a pipeline flush.

Parameters:
- DEPTH, `RobDepth, number of ROB entries; any value ≥ 2, not necessarily a power of two.
- COMMIT, 2, maximum retirements per cycle (1..4).
- WB, 2, number of writeback ports.
- DATA, `AddrWidth, PC width.
- ADDR, $clog2(DEPTH), ROB ID width (derived constant).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous reset, active-high.
- flush  in  1  external flush, active-high; clears all state.
- alloc_en  in  1  dispatch allocates one entry this cycle.
- alloc_id  out  ADDR  ID granted to the current allocation (= head).
- full  out  1  no allocation accepted this cycle.
- wb_en  in  WB  writeback valid per port.
- wb_id  in  WB×ADDR  ROB ID written back.
- wb_exc  in  WB  writeback carries an exception.
- commit_en  out  COMMIT  retire slot k; connects to the PC buffer's re, active-high.
- commit_num  out  $clog2(COMMIT)+1  count of retirements this cycle.
- redirect_id  out  ADDR  ID of the faulting entry; connects to the PC buffer's issue_id.
- redirect_pc  in  DATA  PC of redirect_id (combinational from the PC buffer).
- exc_valid  out  1  one-cycle pulse: exc_pc is valid and the pipeline must flush.
- exc_pc  out  DATA  latched PC of the faulting instruction.

Behaviour:
- Reset (synchronous, highest priority):
  - head, tail and count (width ADDR+1) cleared to 0.
  - valid, done and exc bit vectors cleared.
  - State = RUN. exc_pc = 0, exc_valid = 0.
  - Combinational outputs then read: commit_en = 0, full = 0, alloc_id = 0, redirect_id = 0.
- Priority order: reset, then flush, then FSM.
  - flush has the same effect as reset, except exc_pc holds its value.
  - exc_valid is not asserted on an external flush.
- full = (count == DEPTH) OR (state != RUN).
- Allocation:
  - alloc_en && !full: set valid[head], clear done[head] and exc[head]; head advances by 1, wrapping to 0 at DEPTH.
  - alloc_en && full: ignored, no state change.
- Writeback:
  - wb_en[i] to an entry with valid = 1 sets done, and sets exc if wb_exc[i].
  - Writeback to an entry with valid = 0 is ignored.
  - Two ports writing the same ID in the same cycle: the exc bits are OR-ed.
  - Writeback is visible to commit logic one cycle later (registered bits).
- Commit slot k (0..COMMIT-1), at ID (tail+k) mod DEPTH, is eligible when all hold:
  - state == RUN;
  - k < count;
  - entry has valid = 1, done = 1, exc = 0;
  - every slot below k commits.
- commit_en is combinational from registers, so it can feed the PC buffer's re in the same cycle.
- On commit, the entry's valid bit is cleared and tail advances by commit_num, with wrap.
- Simultaneous allocation and commit: count_next = count + alloc − commit_num. count never exceeds DEPTH and never goes below 0.
- Allocation into a slot freed in the same cycle is not possible, because full is evaluated on the registered count.
- FSM:
  - RUN: if the entry at tail has valid = 1, done = 1, exc = 1, then commit_en = 0 and the next state is CAPTURE. Younger completed entries do not commit.
  - CAPTURE (1 cycle): redirect_id = tail (held stable); exc_pc <= redirect_pc; next state is FLUSH.
  - FLUSH (1 cycle):
    - exc_valid = 1 (registered, asserted during FLUSH).
    - All entries cleared; head = tail = count = 0.
    - Next state is RUN.
  - In CAPTURE and FLUSH, alloc_en and wb_en are ignored.
- redirect_id = tail in all states.
- An exception and a commit of older entries in the same cycle are impossible by construction, since only the tail can trigger the exception.

Optional Feature:
- ROB_COMMIT_STALL_CNT_EN defined:
  - Adds output stall_cnt (32 bits).
  - Saturating counter, incremented each RUN cycle with count > 0 and commit_num == 0.
  - Cleared by reset only; not cleared by flush.
- Undefined: port and logic are absent; behaviour is otherwise identical.

Test Plan (DEPTH=8, COMMIT=2, WB=2):
- Reset, then allocate 8 entries on consecutive cycles → alloc_id 0..7, full = 1 after the 8th; a 9th alloc_en is ignored and head stays 0.
- With IDs 0..3 allocated: writeback IDs 1 and 0 in one cycle → next cycle commit_en = 2'b11, commit_num = 2, tail = 2.
- Writeback ID 1 only → commit_en = 0. Then writeback ID 0 → the next cycle commits both 0 and 1.
- Fill to 8, commit 2 while allocating 1 → count = 7, head wraps to 1, tail = 2, full = 0.
- Writeback ID 0 with wb_exc = 1, redirect_pc = 0x1000 → CAPTURE next cycle, then exc_valid pulses with exc_pc = 0x1000, count = 0, state back to RUN; alloc_en during CAPTURE/FLUSH is ignored.
- Assert flush while in CAPTURE → state RUN, no exc_valid, exc_pc keeps its old value. Assert reset mid-commit → all outputs 0 on the next cycle.
